// File: rtl/hdng_err_gen.sv
// Heading-error front end: registers actual-desired heading, saturates to 10 bits, tracks settling.
// Latency 2 cycles strobe->hdng_vld, no backpressure; optional err_diff output under `ERR_DIFF_EN.
module hdng_err_gen #(
  parameter int TOL        = 32,
  parameter int SETTLE_CNT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        moving,
  input  logic [11:0] dsrd_hdng,
  input  logic [11:0] actual_hdng,
  input  logic        hdng_vld_in,
  output logic [9:0]  err_sat,
  output logic        hdng_vld,
  output logic        at_hdng
`ifdef ERR_DIFF_EN
  ,
  output logic [10:0] err_diff
`endif
);

  localparam int                CW       = (SETTLE_CNT < 2) ? 1 : $clog2(SETTLE_CNT + 1);
  localparam logic [CW-1:0]     CNT_MAX  = CW'(SETTLE_CNT);
  localparam logic [10:0]       TOL_W    = 11'(TOL);

  logic [11:0]   err_raw_q, err_raw_d;
  logic          v1_q, v1_d;
  logic [9:0]    err_sat_q, err_sat_d;
  logic          hdng_vld_q, hdng_vld_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          at_hdng_q, at_hdng_d;
  logic [11:0]   dsrd_q, dsrd_d;
  logic [9:0]    sat_val;
  logic [10:0]   err_abs;
  logic          on_hdng;

`ifdef ERR_DIFF_EN
  logic [9:0]    prev_q, prev_d;
  logic          prev_vld_q, prev_vld_d;
  logic [10:0]   err_diff_q, err_diff_d;
`endif

  always_comb begin
    // Clamp 12-bit wrapped error to [-512,+511]; in range iff bits 11:9 agree.
    sat_val = err_raw_q[9:0];
    if (!err_raw_q[11] && (err_raw_q[10:9] != 2'b00))
      sat_val = 10'h1FF;
    else if (err_raw_q[11] && (err_raw_q[10:9] != 2'b11))
      sat_val = 10'h200;

    err_raw_d  = hdng_vld_in ? (actual_hdng - dsrd_hdng) : err_raw_q;
    v1_d       = hdng_vld_in;
    err_sat_d  = v1_q ? sat_val : err_sat_q;
    hdng_vld_d = v1_q;
    dsrd_d     = dsrd_hdng;

    // Widened magnitude so -512 maps to 512 rather than wrapping negative.
    err_abs = err_sat_q[9] ? (11'd0 - {err_sat_q[9], err_sat_q}) : {1'b0, err_sat_q};
    on_hdng = (err_abs < TOL_W);

    cnt_d = cnt_q;
    if (!moving)
      cnt_d = '0;
    else if (dsrd_hdng != dsrd_q)
      cnt_d = '0;
    else if (hdng_vld_q)
      cnt_d = !on_hdng ? '0 : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1);

    at_hdng_d = moving && (cnt_d == CNT_MAX);

`ifdef ERR_DIFF_EN
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q && moving;
    err_diff_d = err_diff_q;
    if (v1_q) begin
      err_diff_d = (prev_vld_q && moving) ?
                   ({sat_val[9], sat_val} - {prev_q[9], prev_q}) : 11'd0;
      prev_d     = sat_val;
      prev_vld_d = moving;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_raw_q  <= '0;
      v1_q       <= 1'b0;
      err_sat_q  <= '0;
      hdng_vld_q <= 1'b0;
      cnt_q      <= '0;
      at_hdng_q  <= 1'b0;
      dsrd_q     <= '0;
`ifdef ERR_DIFF_EN
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      err_diff_q <= '0;
`endif
    end else begin
      err_raw_q  <= err_raw_d;
      v1_q       <= v1_d;
      err_sat_q  <= err_sat_d;
      hdng_vld_q <= hdng_vld_d;
      cnt_q      <= cnt_d;
      at_hdng_q  <= at_hdng_d;
      dsrd_q     <= dsrd_d;
`ifdef ERR_DIFF_EN
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
      err_diff_q <= err_diff_d;
`endif
    end
  end

  assign err_sat  = err_sat_q;
  assign hdng_vld = hdng_vld_q;
  assign at_hdng  = at_hdng_q;
`ifdef ERR_DIFF_EN
  assign err_diff = err_diff_q;
`endif

endmodule

// File: tb/tb_hdng_err_gen.sv
// Directed bench for hdng_err_gen; err_diff checks are built when ERR_DIFF_EN is defined.
module tb_hdng_err_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        moving;
  logic [11:0] dsrd_hdng;
  logic [11:0] actual_hdng;
  logic        hdng_vld_in;
  logic [9:0]  err_sat;
  logic        hdng_vld;
  logic        at_hdng;
`ifdef ERR_DIFF_EN
  logic [10:0] err_diff;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hdng_err_gen #(.TOL(32), .SETTLE_CNT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .moving      (moving),
    .dsrd_hdng   (dsrd_hdng),
    .actual_hdng (actual_hdng),
    .hdng_vld_in (hdng_vld_in),
    .err_sat     (err_sat),
    .hdng_vld    (hdng_vld),
    .at_hdng     (at_hdng)
`ifdef ERR_DIFF_EN
    ,
    .err_diff    (err_diff)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One strobe, then wait until the resulting pulse has been consumed by the settle logic.
  task automatic sample(input logic [11:0] act);
    actual_hdng = act;
    hdng_vld_in = 1'b1;
    step();
    hdng_vld_in = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; moving = 1'b1; dsrd_hdng = '0; actual_hdng = '0; hdng_vld_in = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
    n_checks++;
    if (err_sat !== 10'd0) begin n_fail++; $display("FAIL reset_err_sat got %h want 000", err_sat); end
    n_checks++;
    if (hdng_vld !== 1'b0) begin n_fail++; $display("FAIL reset_hdng_vld got %b want 0", hdng_vld); end
    n_checks++;
    if (at_hdng !== 1'b0) begin n_fail++; $display("FAIL reset_at_hdng got %b want 0", at_hdng); end
  endtask

  task automatic test_latency();
    dsrd_hdng = 12'd0; actual_hdng = 12'd100; hdng_vld_in = 1'b1;
    step();
    hdng_vld_in = 1'b0;
    n_checks++;
    if (hdng_vld !== 1'b0) begin n_fail++; $display("FAIL lat_t1_vld got %b want 0", hdng_vld); end
    step();
    n_checks++;
    if (hdng_vld !== 1'b1) begin n_fail++; $display("FAIL lat_t2_vld got %b want 1", hdng_vld); end
    n_checks++;
    if (err_sat !== 10'd100) begin n_fail++; $display("FAIL lat_t2_err got %0d want 100", err_sat); end
    step();
    n_checks++;
    if (hdng_vld !== 1'b0) begin n_fail++; $display("FAIL lat_t3_vld got %b want 0", hdng_vld); end
    n_checks++;
    if (err_sat !== 10'd100) begin n_fail++; $display("FAIL lat_hold_err got %0d want 100", err_sat); end
  endtask

  task automatic test_saturation();
    dsrd_hdng = 12'd0;
    sample(12'h700);
    n_checks++;
    if (err_sat !== 10'h1FF) begin n_fail++; $display("FAIL sat_pos got %h want 1ff", err_sat); end
    sample(12'h900);
    n_checks++;
    if (err_sat !== 10'h200) begin n_fail++; $display("FAIL sat_neg got %h want 200", err_sat); end
    dsrd_hdng = 12'h7F0;
    sample(12'h810);
    n_checks++;
    if (err_sat !== 10'd32) begin n_fail++; $display("FAIL wrap got %h want 020", err_sat); end
  endtask

  task automatic test_settle();
    dsrd_hdng = 12'd0; moving = 1'b1;
    step();
    for (int i = 0; i < 3; i++) sample(12'd10);
    n_checks++;
    if (at_hdng !== 1'b0) begin n_fail++; $display("FAIL settle_3 got %b want 0", at_hdng); end
    // Check the cycle right after the 4th pulse.
    actual_hdng = 12'd10; hdng_vld_in = 1'b1;
    step();
    hdng_vld_in = 1'b0;
    step();
    n_checks++;
    if (at_hdng !== 1'b0) begin n_fail++; $display("FAIL settle_4_pulse got %b want 0", at_hdng); end
    step();
    n_checks++;
    if (at_hdng !== 1'b1) begin n_fail++; $display("FAIL settle_4_after got %b want 1", at_hdng); end
    sample(12'd40);
    n_checks++;
    if (at_hdng !== 1'b0) begin n_fail++; $display("FAIL settle_out_tol got %b want 0", at_hdng); end

    for (int i = 0; i < 4; i++) sample(12'd31);
    n_checks++;
    if (at_hdng !== 1'b1) begin n_fail++; $display("FAIL settle_tol_m1 got %b want 1", at_hdng); end
    sample(12'hFE0);
    n_checks++;
    if (at_hdng !== 1'b0) begin n_fail++; $display("FAIL settle_neg_tol got %b want 0", at_hdng); end

    for (int i = 0; i < 4; i++) sample(12'd10);
    n_checks++;
    if (at_hdng !== 1'b1) begin n_fail++; $display("FAIL settle_rebuild got %b want 1", at_hdng); end
    dsrd_hdng = 12'd5;
    step();
    n_checks++;
    if (at_hdng !== 1'b0) begin n_fail++; $display("FAIL settle_dsrd_chg got %b want 0", at_hdng); end

    for (int i = 0; i < 4; i++) sample(12'd15);
    n_checks++;
    if (at_hdng !== 1'b1) begin n_fail++; $display("FAIL settle_rebuild2 got %b want 1", at_hdng); end
    moving = 1'b0;
    step();
    n_checks++;
    if (at_hdng !== 1'b0) begin n_fail++; $display("FAIL settle_stop got %b want 0", at_hdng); end
    sample(12'd15);
    n_checks++;
    if (at_hdng !== 1'b0) begin n_fail++; $display("FAIL settle_stopped got %b want 0", at_hdng); end
    n_checks++;
    if (err_sat !== 10'd10) begin n_fail++; $display("FAIL stopped_err got %0d want 10", err_sat); end
    moving = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    dsrd_hdng = 12'd0;
    step();
    actual_hdng = 12'd5; hdng_vld_in = 1'b1;
    step();
    actual_hdng = 12'd6;
    step();
    n_checks++;
    if (hdng_vld !== 1'b1 || err_sat !== 10'd5) begin n_fail++; $display("FAIL b2b_0 got vld=%b err=%0d want 1/5", hdng_vld, err_sat); end
    actual_hdng = 12'd7;
    step();
    hdng_vld_in = 1'b0;
    n_checks++;
    if (hdng_vld !== 1'b1 || err_sat !== 10'd6) begin n_fail++; $display("FAIL b2b_1 got vld=%b err=%0d want 1/6", hdng_vld, err_sat); end
    step();
    n_checks++;
    if (hdng_vld !== 1'b1 || err_sat !== 10'd7) begin n_fail++; $display("FAIL b2b_2 got vld=%b err=%0d want 1/7", hdng_vld, err_sat); end
    step();
    n_checks++;
    if (hdng_vld !== 1'b0) begin n_fail++; $display("FAIL b2b_end got %b want 0", hdng_vld); end

    // Reset with a sample captured in stage 1 only.
    actual_hdng = 12'd9; hdng_vld_in = 1'b1;
    step();
    hdng_vld_in = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++;
    if (err_sat !== 10'd0 || hdng_vld !== 1'b0 || at_hdng !== 1'b0) begin
      n_fail++; $display("FAIL rst_async got err=%0d vld=%b at=%b want 0/0/0", err_sat, hdng_vld, at_hdng);
    end
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (hdng_vld !== 1'b0 || err_sat !== 10'd0) begin
        n_fail++; $display("FAIL rst_drop_%0d got vld=%b err=%0d want 0/0", i, hdng_vld, err_sat);
      end
    end
  endtask

`ifdef ERR_DIFF_EN
  task automatic test_err_diff();
    dsrd_hdng = 12'd0; moving = 1'b1;
    step();
    sample(12'd100);
    n_checks++;
    if (err_diff !== 11'd0) begin n_fail++; $display("FAIL diff_first got %h want 000", err_diff); end
    sample(12'd60);
    n_checks++;
    if (err_diff !== 11'h7D8) begin n_fail++; $display("FAIL diff_neg40 got %h want 7d8", err_diff); end
    moving = 1'b0;
    step();
    moving = 1'b1;
    step();
    sample(12'd20);
    n_checks++;
    if (err_diff !== 11'd0) begin n_fail++; $display("FAIL diff_after_stop got %h want 000", err_diff); end
    sample(12'd30);
    n_checks++;
    if (err_diff !== 11'd10) begin n_fail++; $display("FAIL diff_pos10 got %h want 00a", err_diff); end
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_saturation();
    test_settle();
    test_back_to_back();
`ifdef ERR_DIFF_EN
    test_err_diff();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
